cdc_tx_fifo: RTL and testbench
==============================

Name: cdc_tx_fifo

Overview:
Single-clock transmit buffer in the source (A) domain, directly upstream of the 2-phase CDC handshake. It absorbs bursts from a producer that cannot tolerate the multi-cycle round trip of the handshake. It drains one word per completed handshake and holds output data stable while a transfer is pending. It provides occupancy status and a synchronous flush.

Parameters:
G_WIDTH, 4, data word width in bits (>=1)
G_DEPTH, 8, storage entries; power of two, >=2
G_CNT_W, $clog2(G_DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
i_clk  in  1  clock (source domain A clock)
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  synchronous flush of all stored words
i_valid  in  1  producer word valid
o_ready  out  1  FIFO can accept a word
i_data  in  G_WIDTH  producer data
o_valid  out  1  word available to CDC stage (drives its i_valid_A)
i_ready  in  1  CDC stage accepts (driven from its o_ready_A)
o_data  out  G_WIDTH  head-of-FIFO data (drives its i_data_A)
o_count  out  G_CNT_W  stored-word count, 0..G_DEPTH
o_full  out  1  count == G_DEPTH
o_empty  out  1  count == 0

Behaviour:
- Reset is asynchronous on i_rst_n low and released synchronously by design.
  - Reset values: write/read pointers 0, o_count 0, o_empty 1, o_full 0, o_valid 0, o_ready 0.
  - Storage contents and o_data are undefined.
- o_ready is registered. It is 0 during reset, rises on the first i_clk edge after release, and thereafter equals !full for the next-state occupancy. It never depends combinationally on i_ready.
- Push occurs when i_valid && o_ready at the clock edge. i_data is written to mem[wr_ptr] and wr_ptr advances.
- Pop occurs when o_valid && i_ready at the clock edge. rd_ptr advances.
- Pointers are G_CNT_W bits wide, with the extra MSB used for wrap.
  - Index = low $clog2(G_DEPTH) bits; wrap from G_DEPTH-1 to 0 is natural modulo.
  - full: indices equal and MSBs differ. empty: pointers equal.
- o_count = wr_ptr - rd_ptr (modulo 2^G_CNT_W). o_full, o_empty and o_valid (= !o_empty) all derive from registered pointers.
- First-word fall-through: o_data = mem[rd_ptr].
  - A push into an empty FIFO makes o_valid 1 with that data on the next cycle (latency 1).
- Stability: while o_valid && !i_ready, o_data and o_valid hold. The head slot is never overwritten because a write to it requires full, and o_ready is low when full.
- Simultaneous push and pop with 0 < count < G_DEPTH: both proceed and count is unchanged.
  - Empty FIFO: pop is impossible (o_valid 0); push only.
  - Full FIFO: push is impossible; o_ready rises the cycle after a pop.
- Flush (i_flush=1 at an edge):
  - rd_ptr <= wr_ptr, so count becomes 0 and o_valid is 0 next cycle.
  - Flush takes priority: any same-cycle push or pop is discarded and does not count.
  - o_ready becomes 1 next cycle.
- Flush while the CDC stage has a handshake in flight:
  - The downstream stage has already captured the word, so the flush does not recall it.
  - Flush is only meaningful for words not yet popped.
- Reset mid-burst: all stored words are lost and outputs immediately take reset values. No partial pop is reported.
- No overflow or underflow is possible through the handshake. Protocol violations, such as i_valid dropping before acceptance, are permitted on the producer side; a word is stored only on the push condition.

Test Plan:
- Reset, then idle: after i_rst_n release, o_ready = 1 one edge later; o_count = 0, o_empty = 1, o_valid = 0.
- Single word: push 4'hA into empty FIFO, hold i_ready = 0 for 5 cycles.
  - o_valid = 1 and o_data = 4'hA from cycle +1 and stable for all 5 cycles.
  - i_ready = 1 for one cycle pops it; o_empty = 1 next cycle.
- Fill to full (G_DEPTH = 8): push 0..7 with i_ready = 0.
  - o_count = 8, o_full = 1, o_ready = 0; an extra i_valid with data 4'hF is not stored.
  - One pop yields data 0, and o_ready = 1 next cycle.
- Wrap-around and concurrent traffic: stream 20 words 0..19 with i_ready toggling 1-of-3 cycles and simultaneous push/pop.
  - Output order is exactly 0..19; o_count never exceeds 8; data is stable whenever o_valid && !i_ready.
- Flush: with count = 5, assert i_flush together with i_valid = 1 and i_ready = 1.
  - Next cycle: o_count = 0, o_valid = 0, and the same-cycle word is not stored.
  - A subsequent push of 4'h3 appears with latency 1.
- Async reset mid-burst: drop i_rst_n between edges with count = 6.
  - Immediately o_valid = 0, o_ready = 0, o_count = 0; normal operation resumes after release.

Source files
------------

// File: rtl/cdc_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_tx_fifo
//  Purpose  : Source-domain transmit buffer placed ahead of a 2-phase CDC
//             handshake. It absorbs producer bursts, drains one word per
//             completed handshake, and holds the head word stable while a
//             transfer is pending. It also reports occupancy and supports a
//             synchronous flush.
//  Ports    : i_clk, i_rst_n    - source clock, async active-low reset
//             i_flush           - drop every stored word (synchronous)
//             i_valid/o_ready   - producer side handshake, i_data word
//             o_valid/i_ready   - CDC side handshake, o_data head word
//             o_count           - stored words 0..G_DEPTH
//             o_full/o_empty    - occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module cdc_tx_fifo #(
   parameter int G_WIDTH = 4,
   parameter int G_DEPTH = 8,
   parameter int G_CNT_W = $clog2(G_DEPTH) + 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_flush,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [G_WIDTH-1:0] i_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [G_WIDTH-1:0] o_data,
   output logic [G_CNT_W-1:0] o_count,
   output logic               o_full,
   output logic               o_empty
);

   localparam int                 c_IDX_W = $clog2(G_DEPTH);
   localparam logic [G_CNT_W-1:0] c_DEPTH = G_CNT_W'(G_DEPTH);

   logic [G_WIDTH-1:0] r_mem [G_DEPTH];
   logic [G_CNT_W-1:0] r_wr_ptr;
   logic [G_CNT_W-1:0] r_rd_ptr;
   logic               r_ready;

   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic [G_CNT_W-1:0] w_wr_next;
   logic [G_CNT_W-1:0] w_rd_next;
   logic [G_CNT_W-1:0] w_cnt_next;

   // Status is derived only from the registered pointers.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[G_CNT_W-1] != r_rd_ptr[G_CNT_W-1]) &&
                    (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);

   assign w_push = i_valid & r_ready;
   assign w_pop  = ~w_empty & i_ready;

   assign w_wr_next  = r_wr_ptr + {{(G_CNT_W-1){1'b0}}, w_push};
   assign w_rd_next  = r_rd_ptr + {{(G_CNT_W-1){1'b0}}, w_pop};
   // Ready is registered from next-state occupancy so it never depends
   // combinationally on i_ready.
   assign w_cnt_next = w_wr_next - w_rd_next;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ready  <= 1'b0;
      end else if (i_flush) begin
         // Flush wins: same-cycle push and pop are both discarded.
         r_rd_ptr <= r_wr_ptr;
         r_ready  <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_next;
         r_rd_ptr <= w_rd_next;
         r_ready  <= (w_cnt_next != c_DEPTH);
      end
   end

   // Storage has no reset. The head slot can only be written when full,
   // and ready is low when full, so the presented word never changes
   // under a pending transfer.
   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush) begin
         r_mem[r_wr_ptr[c_IDX_W-1:0]] <= i_data;
      end
   end

   assign o_ready = r_ready;
   assign o_valid = ~w_empty;
   assign o_data  = r_mem[r_rd_ptr[c_IDX_W-1:0]];
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_cdc_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdc_tx_fifo
//  Purpose  : Self-checking bench for cdc_tx_fifo. A queue scoreboard holds
//             the words the bench expects to leave the FIFO; a monitor on the
//             falling edge compares DUT status and head data to it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_tx_fifo;

   localparam int c_WIDTH = 4;
   localparam int c_DEPTH = 8;
   localparam int c_CNT_W = $clog2(c_DEPTH) + 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               flush;
   logic               valid;
   logic               ready_out;
   logic [c_WIDTH-1:0] data_in;
   logic               valid_out;
   logic               ready_in;
   logic [c_WIDTH-1:0] data_out;
   logic [c_CNT_W-1:0] count;
   logic               full;
   logic               empty;

   int n_checks = 0;
   int n_fails  = 0;
   int n_pops   = 0;

   logic [c_WIDTH-1:0] sb_q[$];
   logic               m_ready = 1'b0;

   always #5 clk = ~clk;

   cdc_tx_fifo #(
      .G_WIDTH (c_WIDTH),
      .G_DEPTH (c_DEPTH)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_flush (flush),
      .i_valid (valid),
      .o_ready (ready_out),
      .i_data  (data_in),
      .o_valid (valid_out),
      .i_ready (ready_in),
      .o_data  (data_out),
      .o_count (count),
      .o_full  (full),
      .o_empty (empty)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: outputs are settled at the falling edge; the input
   // values seen here are the ones the next rising edge will act on.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         m_ready = 1'b0;
      end else begin
         check("mon_count", 32'(count), 32'(sb_q.size()));
         check("mon_valid", 32'(valid_out), 32'(sb_q.size() != 0));
         check("mon_empty", 32'(empty), 32'(sb_q.size() == 0));
         check("mon_full", 32'(full), 32'(sb_q.size() == c_DEPTH));
         check("mon_ready", 32'(ready_out), 32'(m_ready));
         if (sb_q.size() != 0) check("mon_data", 32'(data_out), 32'(sb_q[0]));
         if (flush) begin
            sb_q.delete();
            m_ready = 1'b1;
         end else begin
            if (sb_q.size() != 0 && ready_in) begin
               void'(sb_q.pop_front());
               n_pops++;
            end
            if (valid && m_ready) sb_q.push_back(data_in);
            m_ready = (sb_q.size() != c_DEPTH);
         end
      end
   end

   task automatic push_word(input logic [c_WIDTH-1:0] d);
      valid   = 1'b1;
      data_in = d;
      cycle();
      valid   = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      ready_in = 1'b1;
      while (valid_out && n < budget) begin
         cycle();
         n++;
      end
      ready_in = 1'b0;
      check("drain_timeout", 32'(valid_out), 32'd0);
   endtask

   initial begin
      int idx;
      int cyc;
      int budget;
      logic acc;

      rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready_in = 1'b0; data_in = '0;
      repeat (3) cycle();

      // Reset state
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_ready", 32'(ready_out), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      rst_n = 1'b1;
      check("rel_ready_pre", 32'(ready_out), 32'd0);
      cycle();
      check("rel_ready_post", 32'(ready_out), 32'd1);

      // Single word held for five cycles, then popped
      push_word(4'hA);
      for (int i = 0; i < 5; i++) begin
         check("single_valid", 32'(valid_out), 32'd1);
         check("single_data", 32'(data_out), 32'hA);
         cycle();
      end
      ready_in = 1'b1;
      cycle();
      ready_in = 1'b0;
      check("single_empty", 32'(empty), 32'd1);

      // Fill to full, then one rejected word
      for (int i = 0; i < c_DEPTH; i++) push_word(c_WIDTH'(i));
      check("fill_count", 32'(count), 32'd8);
      check("fill_full", 32'(full), 32'd1);
      check("fill_ready", 32'(ready_out), 32'd0);
      push_word(4'hF);
      check("over_count", 32'(count), 32'd8);
      check("full_head", 32'(data_out), 32'h0);
      ready_in = 1'b1;
      cycle();
      ready_in = 1'b0;
      check("pop_ready", 32'(ready_out), 32'd1);
      check("pop_count", 32'(count), 32'd7);
      drain(50);

      // Streaming with wrap-around and concurrent push/pop
      n_pops = 0;
      idx = 0;
      cyc = 0;
      while (idx < 20 && cyc < 500) begin
         valid    = 1'b1;
         data_in  = c_WIDTH'(idx);
         ready_in = (cyc % 3 == 0);
         acc      = ready_out;
         cycle();
         if (acc) idx++;
         cyc++;
      end
      valid = 1'b0;
      check("stream_sent", 32'(idx), 32'd20);
      budget = 0;
      while (valid_out && budget < 200) begin
         ready_in = (cyc % 3 == 0);
         cycle();
         cyc++;
         budget++;
      end
      ready_in = 1'b0;
      check("stream_drained", 32'(valid_out), 32'd0);
      check("stream_pops", 32'(n_pops), 32'd20);

      // Flush with simultaneous push and pop
      for (int i = 0; i < 5; i++) push_word(c_WIDTH'(4'h8 + i));
      check("pre_flush_count", 32'(count), 32'd5);
      flush = 1'b1; valid = 1'b1; ready_in = 1'b1; data_in = 4'h6;
      cycle();
      flush = 1'b0; valid = 1'b0; ready_in = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_valid", 32'(valid_out), 32'd0);
      check("flush_ready", 32'(ready_out), 32'd1);
      push_word(4'h3);
      check("post_flush_valid", 32'(valid_out), 32'd1);
      check("post_flush_data", 32'(data_out), 32'h3);
      check("post_flush_count", 32'(count), 32'd1);
      drain(20);

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < 6; i++) push_word(c_WIDTH'(i + 2));
      check("pre_rst_count", 32'(count), 32'd6);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(valid_out), 32'd0);
      check("arst_ready", 32'(ready_out), 32'd0);
      check("arst_count", 32'(count), 32'd0);
      cycle();
      rst_n = 1'b1;
      cycle();
      check("resume_ready", 32'(ready_out), 32'd1);
      push_word(4'h5);
      check("resume_data", 32'(data_out), 32'h5);
      drain(20);
      repeat (2) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
